vector_sequencer: RTL and testbench
===================================

// Module: vector_sequencer
// PURPOSE
//  Multi-cycle command controller for the vector CFU. Accepts CPU commands over the
//  cmd/rsp handshake and owns the architectural vtype/vl state. Steps register-group ops
//  (LMUL = 1/2/4/8) through the register file one 256-bit register per cycle. Drives the
//  register-file selects, ALU mode/operand mux and result-bus select; replaces combinational
//  decode and the vtype latch.
// PARAMETERS
//  REG_ADDR_W  5    register-file address width (32 vector registers)
//  VLEN_BITS   256  bits per vector register; VLMAX = (VLEN_BITS/8) << vlmul
//  VL_W        9    width of vl (holds 0..256)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   asynchronous, active-high
//  cmd_valid      in   1   command offered by CPU
//  cmd_ready      out  1   1 only in IDLE
//  cmd_payload_function_id in 10  [2:0] opcode, [4:3] alu_mode, rest ignored
//  cmd_payload_inputs_0 in 32  [4:0] vd, [9:5] vs0, [14:10] vs1; AVL for VSETVL
//  cmd_payload_inputs_1 in 32  [7:0] imm for ALU.VI; vtype for VSETVL
//  rsp_valid      out  1   response held until rsp_ready
//  rsp_ready      in   1   CPU accepts response
//  rsp_payload_outputs_0 out 32  result word (see BEHAVIOUR)
//  gacc_in        in   32  group-accumulator output from datapath
//  reg_op0_sel    out  5   source 0 register
//  reg_op1_sel    out  5   source 1 register
//  reg_wb_sel     out  5   write-back register
//  reg_load       out  1   write-back strobe, 1 cycle per register
//  alu_op1_sel    out  1   1 = replicated immediate, 0 = reg_op1
//  alu_mode       out  2   ALU operation
//  bus_sel        out  2   00 gacc, 01 alu, 10 mul, 11 byte acc
//  vtype          out  32  current vtype register
//  vlmul          out  3   vtype[2:0]
//  vl             out  9   current vector length
// BEHAVIOUR
//  Reset: state = IDLE. All outputs 0 except cmd_ready = 1. vtype = vl = 0.
//  Reset mid-operation aborts at once: reg_load drops asynchronously, no response issued.
//  Opcodes: 0 VSETVL, 1 ALU.VV (bus 01), 2 ALU.VI (bus 01, alu_op1_sel = 1),
//    3 VMUL (bus 10), 4 BACC (bus 11, 1 reg), 5 GACC (bus 00, no write), 6/7 illegal.
//  nregs = 1 << vlmul for vlmul 0..3. vlmul 4..7 (fractional) is treated as nregs = 1.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: cmd_ready = 1. On cmd_valid, latch function_id/inputs, set count = 0.
//     VSETVL, GACC, illegal and misaligned commands go directly to RESP.
//     All other commands go to EXEC.
//   EXEC: drive op0 = vs0+count, op1 = vs1+count, wb = vd+count (5-bit wrap mod 32).
//     Drive reg_load = 1. count++. Leave to RESP after count == nregs-1.
//     BACC runs 1 cycle regardless of nregs.
//   RESP: rsp_valid = 1, payload stable. cmd_ready = 0; cmd_valid is ignored.
//     Leave on rsp_ready; IDLE is re-entered next cycle (no back-to-back accept).
//  Latency: accept at T, EXEC T+1..T+n, rsp_valid from T+n+1.
//    Single-cycle commands: rsp_valid at T+1.
//  VSETVL: at the accept edge, vtype <= inputs_1 and vl <= min(AVL, VLMAX).
//    Payload = new vl. Compare at full 32 bits so AVL > 256 saturates.
//  Payloads: ALU/MUL/BACC = vl. GACC = gacc_in sampled in IDLE on accept.
//  Illegal: opcode 6/7, or (opcode 1-3 and vd, vs0 or vs1 not a multiple of nregs).
//    Action: no reg_load, payload = 32'hFFFF_FFFF, vtype/vl unchanged.
//  In IDLE/RESP: selects hold their last value, reg_load = 0.
// TESTING
//  T1: VSETVL AVL=100, vtype=1 -> rsp at T+1, payload 64, vlmul=1, vl=64.
//  T2: vlmul=2, ALU.VV vd=4 vs0=8 vs1=12 -> reg_load 4 cycles,
//      wb 4..7, op0 8..11, op1 12..15, rsp at T+5, payload=vl.
//  T3: vlmul=2, VMUL vd=3 -> no reg_load, rsp at T+1, payload FFFF_FFFF.
//  T4: rsp_ready low 3 cycles with cmd_valid high -> rsp_valid/payload held,
//      cmd_ready 0, second command accepted only after IDLE.
//  T5: reset asserted in 2nd EXEC cycle of 4 -> reg_load=0 immediately,
//      vtype=vl=0, IDLE, no rsp.
//  T6: GACC with gacc_in=0x1234 -> bus_sel 00, no reg_load, payload 0x1234 at T+1.

Source files
------------

// File: rtl/vector_sequencer.sv
// ---------------------------------------------------------------------------
// vector_sequencer
//
// Purpose:
//   Multi-cycle command controller for the vector CFU. Accepts CPU commands
//   over the cmd/rsp handshake, owns the architectural vtype/vl state and
//   steps register-group operations (LMUL = 1/2/4/8) through the register
//   file, one vector register per cycle. It also drives the register-file
//   selects, the ALU mode/operand mux and the result-bus select.
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   cmd_valid / cmd_ready      command handshake (ready only in IDLE)
//   cmd_payload_function_id    [2:0] opcode, [4:3] alu_mode
//   cmd_payload_inputs_0       [4:0] vd, [9:5] vs0, [14:10] vs1; AVL for VSETVL
//   cmd_payload_inputs_1       ALU.VI immediate (used by datapath); vtype for VSETVL
//   rsp_valid / rsp_ready      response handshake, payload held until accepted
//   rsp_payload_outputs_0      result word
//   gacc_in                    group-accumulator value from the datapath
//   reg_op0_sel/op1_sel/wb_sel register-file selects
//   reg_load                   write-back strobe, one cycle per register
//   alu_op1_sel, alu_mode      ALU operand-1 mux and operation
//   bus_sel                    result bus: 00 gacc, 01 alu, 10 mul, 11 byte acc
//   vtype, vlmul, vl           architectural vector state
// ---------------------------------------------------------------------------
module vector_sequencer #(
  parameter int REG_ADDR_W = 5,
  parameter int VLEN_BITS  = 256,
  parameter int VL_W       = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [9:0]            cmd_payload_function_id,
  input  logic [31:0]           cmd_payload_inputs_0,
  input  logic [31:0]           cmd_payload_inputs_1,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_payload_outputs_0,
  input  logic [31:0]           gacc_in,
  output logic [REG_ADDR_W-1:0] reg_op0_sel,
  output logic [REG_ADDR_W-1:0] reg_op1_sel,
  output logic [REG_ADDR_W-1:0] reg_wb_sel,
  output logic                  reg_load,
  output logic                  alu_op1_sel,
  output logic [1:0]            alu_mode,
  output logic [1:0]            bus_sel,
  output logic [31:0]           vtype,
  output logic [2:0]            vlmul,
  output logic [VL_W-1:0]       vl
);

  localparam int VLMAX_BASE = VLEN_BITS / 8;

  localparam logic [2:0] OP_VSETVL = 3'd0;
  localparam logic [2:0] OP_ALU_VV = 3'd1;
  localparam logic [2:0] OP_ALU_VI = 3'd2;
  localparam logic [2:0] OP_VMUL   = 3'd3;
  localparam logic [2:0] OP_BACC   = 3'd4;
  localparam logic [2:0] OP_GACC   = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [2:0] count_reg, count_next;
  logic [2:0] last_count_reg;

  logic [31:0]     vtype_reg;
  logic [VL_W-1:0] vl_reg;
  logic [31:0]     rsp_data_reg;
  logic [1:0]      bus_sel_reg;
  logic [1:0]      alu_mode_reg;
  logic            alu_op1_sel_reg;

  // Register-group channels: 0 = vd (write-back), 1 = vs0, 2 = vs1.
  logic [REG_ADDR_W-1:0] base_reg  [3];
  logic [REG_ADDR_W-1:0] hold_reg  [3];
  logic [REG_ADDR_W-1:0] sel_exec  [3];
  logic [REG_ADDR_W-1:0] sel_out   [3];
  logic [REG_ADDR_W-1:0] cmd_field [3];

  // ---------------------------------------------------------------- decode
  logic [2:0]  cmd_op;
  logic        accept;
  logic [2:0]  group_last;   // nregs-1 for the current vtype
  logic        misaligned;
  logic        illegal;
  logic        single_cycle;
  logic [2:0]  new_vlmul;
  logic [31:0] vlmax32;
  logic [31:0] avl;
  logic [VL_W-1:0] new_vl;
  logic        unused_fid_bits;

  assign cmd_op          = cmd_payload_function_id[2:0];
  assign unused_fid_bits = ^cmd_payload_function_id[9:5];
  assign accept          = (state_reg == IDLE) && cmd_valid;

  // Fractional LMUL (vlmul 4..7) still occupies a single register.
  always_comb begin
    case (vtype_reg[2:0])
      3'd1:    group_last = 3'd1;
      3'd2:    group_last = 3'd3;
      3'd3:    group_last = 3'd7;
      default: group_last = 3'd0;
    endcase
  end

  // A register-group operand must start on a multiple of nregs.
  assign misaligned = ((cmd_op == OP_ALU_VV) || (cmd_op == OP_ALU_VI) || (cmd_op == OP_VMUL)) &&
                      (|((cmd_field[0] | cmd_field[1] | cmd_field[2]) &
                         REG_ADDR_W'(group_last)));
  assign illegal      = (cmd_op > OP_GACC) || misaligned;
  assign single_cycle = (cmd_op == OP_VSETVL) || (cmd_op == OP_GACC) || illegal;

  // VLMAX follows the incoming vtype; fractional LMUL is capped at one register.
  assign new_vlmul = cmd_payload_inputs_1[2:0];
  assign vlmax32   = new_vlmul[2] ? 32'(VLMAX_BASE) : (32'(VLMAX_BASE) << new_vlmul[1:0]);
  assign avl       = cmd_payload_inputs_0;
  // Full 32-bit compare so any AVL above VLMAX saturates.
  assign new_vl    = (avl < vlmax32) ? avl[VL_W-1:0] : vlmax32[VL_W-1:0];

  // -------------------------------------------------------- select channels
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sel
      assign cmd_field[gi] = cmd_payload_inputs_0[gi*REG_ADDR_W +: REG_ADDR_W];
      // Natural-width add wraps modulo the register count.
      assign sel_exec[gi]  = base_reg[gi] + REG_ADDR_W'(count_reg);
      assign sel_out[gi]   = (state_reg == EXEC) ? sel_exec[gi] : hold_reg[gi];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          base_reg[gi] <= '0;
          hold_reg[gi] <= '0;
        end else begin
          if (accept && !single_cycle) begin
            base_reg[gi] <= cmd_field[gi];
          end
          if (state_reg == EXEC) begin
            hold_reg[gi] <= sel_exec[gi];
          end
        end
      end
    end
  endgenerate

  assign reg_wb_sel  = sel_out[0];
  assign reg_op0_sel = sel_out[1];
  assign reg_op1_sel = sel_out[2];

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    reg_load   = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          count_next = '0;
          state_next = single_cycle ? RESP : EXEC;
        end
      end
      EXEC: begin
        reg_load = 1'b1;
        if (count_reg == last_count_reg) begin
          state_next = RESP;
        end else begin
          count_next = count_reg + 3'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------ command / result state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vtype_reg       <= '0;
      vl_reg          <= '0;
      rsp_data_reg    <= '0;
      last_count_reg  <= '0;
      bus_sel_reg     <= '0;
      alu_mode_reg    <= '0;
      alu_op1_sel_reg <= 1'b0;
    end else if (accept) begin
      if (illegal) begin
        rsp_data_reg <= 32'hFFFF_FFFF;
      end else if (cmd_op == OP_VSETVL) begin
        vtype_reg    <= cmd_payload_inputs_1;
        vl_reg       <= new_vl;
        rsp_data_reg <= 32'(new_vl);
      end else begin
        rsp_data_reg    <= (cmd_op == OP_GACC) ? gacc_in : 32'(vl_reg);
        last_count_reg  <= (cmd_op == OP_BACC) ? 3'd0 : group_last;
        alu_mode_reg    <= cmd_payload_function_id[4:3];
        alu_op1_sel_reg <= (cmd_op == OP_ALU_VI);
        case (cmd_op)
          OP_ALU_VV, OP_ALU_VI: bus_sel_reg <= 2'b01;
          OP_VMUL:              bus_sel_reg <= 2'b10;
          OP_BACC:              bus_sel_reg <= 2'b11;
          default:              bus_sel_reg <= 2'b00;
        endcase
      end
    end
  end

  assign rsp_payload_outputs_0 = rsp_data_reg;
  assign bus_sel               = bus_sel_reg;
  assign alu_mode              = alu_mode_reg;
  assign alu_op1_sel           = alu_op1_sel_reg;
  assign vtype                 = vtype_reg;
  assign vlmul                 = vtype_reg[2:0];
  assign vl                    = vl_reg;

endmodule

// File: tb/tb_vector_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vector_sequencer
//
// Directed testbench for vector_sequencer. Commands are driven on the falling
// edge, accepted on the rising edge, and all outputs are sampled on falling
// edges. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_vector_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic [31:0] gacc_in;
  logic [4:0]  reg_op0_sel;
  logic [4:0]  reg_op1_sel;
  logic [4:0]  reg_wb_sel;
  logic        reg_load;
  logic        alu_op1_sel;
  logic [1:0]  alu_mode;
  logic [1:0]  bus_sel;
  logic [31:0] vtype;
  logic [2:0]  vlmul;
  logic [8:0]  vl;

  int checks = 0;
  int errors = 0;

  vector_sequencer dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .gacc_in                 (gacc_in),
    .reg_op0_sel             (reg_op0_sel),
    .reg_op1_sel             (reg_op1_sel),
    .reg_wb_sel              (reg_wb_sel),
    .reg_load                (reg_load),
    .alu_op1_sel             (alu_op1_sel),
    .alu_mode                (alu_mode),
    .bus_sel                 (bus_sel),
    .vtype                   (vtype),
    .vlmul                   (vlmul),
    .vl                      (vl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mkfid(input logic [1:0] mode, input logic [2:0] op);
    return {5'd0, mode, op};
  endfunction

  function automatic logic [31:0] mkregs(input logic [4:0] vd, input logic [4:0] vs0,
                                         input logic [4:0] vs1);
    return {17'd0, vs1, vs0, vd};
  endfunction

  // Called on a falling edge with the DUT in IDLE; returns on the falling edge
  // of the first cycle after acceptance.
  task automatic send(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b);
    $display("cmd fid=%0d in0=%h in1=%h", fid, a, b);
    cmd_payload_function_id = fid;
    cmd_payload_inputs_0    = a;
    cmd_payload_inputs_1    = b;
    cmd_valid               = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset                   = 1'b1;
    cmd_valid               = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0    = '0;
    cmd_payload_inputs_1    = '0;
    rsp_ready               = 1'b1;
    gacc_in                 = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_reg_load",  32'(reg_load),  32'd0);
    check("rst_vtype",     vtype,          32'd0);
    check("rst_vl",        32'(vl),        32'd0);
    check("rst_bus_sel",   32'(bus_sel),   32'd0);
    check("rst_payload",   rsp_payload_outputs_0, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // T1: VSETVL AVL=100 vtype=1 -> VLMAX 64
    send(mkfid(2'd0, 3'd0), 32'd100, 32'd1);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1_payload",   rsp_payload_outputs_0, 32'd64);
    check("t1_vl",        32'(vl), 32'd64);
    check("t1_vlmul",     32'(vlmul), 32'd1);
    check("t1_reg_load",  32'(reg_load), 32'd0);
    @(negedge clk);
    check("t1_idle_ready", 32'(cmd_ready), 32'd1);
    check("t1_idle_rsp",   32'(rsp_valid), 32'd0);

    // Saturation: AVL=1000 with vlmul=3 -> 256
    send(mkfid(2'd0, 3'd0), 32'd1000, 32'd3);
    check("sat_payload", rsp_payload_outputs_0, 32'd256);
    check("sat_vl",      32'(vl), 32'd256);
    @(negedge clk);
    // AVL=300 with vlmul=2 -> 128
    send(mkfid(2'd0, 3'd0), 32'd300, 32'd2);
    check("v2_vl", 32'(vl), 32'd128);
    @(negedge clk);

    // T2: ALU.VV vd=4 vs0=8 vs1=12 over a 4-register group
    send(mkfid(2'd1, 3'd1), mkregs(5'd4, 5'd8, 5'd12), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t2_reg_load",  32'(reg_load),    32'd1);
      check("t2_wb",        32'(reg_wb_sel),  32'(4 + i));
      check("t2_op0",       32'(reg_op0_sel), 32'(8 + i));
      check("t2_op1",       32'(reg_op1_sel), 32'(12 + i));
      check("t2_bus_sel",   32'(bus_sel),     32'd1);
      check("t2_alu_mode",  32'(alu_mode),    32'd1);
      check("t2_op1_sel",   32'(alu_op1_sel), 32'd0);
      check("t2_rsp_early", 32'(rsp_valid),   32'd0);
      @(negedge clk);
    end
    check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t2_payload",   rsp_payload_outputs_0, 32'd128);
    check("t2_load_off",  32'(reg_load), 32'd0);
    check("t2_wb_held",   32'(reg_wb_sel), 32'd7);
    @(negedge clk);
    check("t2_idle_wb",   32'(reg_wb_sel), 32'd7);
    check("t2_idle_op0",  32'(reg_op0_sel), 32'd11);

    // T3: VMUL vd=3 misaligned for nregs=4
    send(mkfid(2'd0, 3'd3), mkregs(5'd3, 5'd8, 5'd12), 32'd0);
    check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t3_reg_load",  32'(reg_load), 32'd0);
    check("t3_payload",   rsp_payload_outputs_0, 32'hFFFF_FFFF);
    check("t3_vl",        32'(vl), 32'd128);
    @(negedge clk);

    // ALU.VI vd=0 vs0=4 vs1=8, alu_mode=2
    send(mkfid(2'd2, 3'd2), mkregs(5'd0, 5'd4, 5'd8), 32'h5A);
    for (int i = 0; i < 4; i++) begin
      check("vi_reg_load", 32'(reg_load),    32'd1);
      check("vi_wb",       32'(reg_wb_sel),  32'(i));
      check("vi_op1_sel",  32'(alu_op1_sel), 32'd1);
      check("vi_alu_mode", 32'(alu_mode),    32'd2);
      @(negedge clk);
    end
    check("vi_rsp_valid", 32'(rsp_valid), 32'd1);
    check("vi_payload",   rsp_payload_outputs_0, 32'd128);
    @(negedge clk);

    // BACC vd=16: one register regardless of group size
    send(mkfid(2'd0, 3'd4), mkregs(5'd16, 5'd0, 5'd0), 32'd0);
    check("bacc_reg_load", 32'(reg_load), 32'd1);
    check("bacc_wb",       32'(reg_wb_sel), 32'd16);
    check("bacc_bus_sel",  32'(bus_sel), 32'd3);
    @(negedge clk);
    check("bacc_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bacc_load_off",  32'(reg_load), 32'd0);
    check("bacc_payload",   rsp_payload_outputs_0, 32'd128);
    @(negedge clk);

    // Illegal opcode 7
    send(mkfid(2'd0, 3'd7), 32'd0, 32'd0);
    check("ill_rsp_valid", 32'(rsp_valid), 32'd1);
    check("ill_reg_load",  32'(reg_load), 32'd0);
    check("ill_payload",   rsp_payload_outputs_0, 32'hFFFF_FFFF);
    check("ill_vtype",     vtype, 32'd2);
    @(negedge clk);

    // T4: response back-pressure with a second command pending
    rsp_ready = 1'b0;
    send(mkfid(2'd0, 3'd0), 32'd50, 32'd2);
    cmd_payload_function_id = mkfid(2'd0, 3'd0);
    cmd_payload_inputs_0    = 32'd20;
    cmd_payload_inputs_1    = 32'd0;
    cmd_valid               = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_rsp_held",   32'(rsp_valid), 32'd1);
      check("t4_payload",    rsp_payload_outputs_0, 32'd50);
      check("t4_cmd_ready",  32'(cmd_ready), 32'd0);
      check("t4_vl_held",    32'(vl), 32'd50);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_idle_rsp",   32'(rsp_valid), 32'd0);
    check("t4_idle_ready", 32'(cmd_ready), 32'd1);
    check("t4_idle_vl",    32'(vl), 32'd50);
    $display("cmd fid=0 in0=%h in1=%h", 32'd20, 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t4_2nd_rsp",     32'(rsp_valid), 32'd1);
    check("t4_2nd_payload", rsp_payload_outputs_0, 32'd20);
    check("t4_2nd_vl",      32'(vl), 32'd20);
    @(negedge clk);
    send(mkfid(2'd0, 3'd0), 32'd300, 32'd2);
    check("t4_restore_vl", 32'(vl), 32'd128);
    @(negedge clk);

    // T5: reset during the 2nd of 4 EXEC cycles
    send(mkfid(2'd1, 3'd1), mkregs(5'd8, 5'd16, 5'd24), 32'd0);
    check("t5_exec1_load", 32'(reg_load), 32'd1);
    @(negedge clk);
    check("t5_exec2_load", 32'(reg_load), 32'd1);
    check("t5_exec2_wb",   32'(reg_wb_sel), 32'd9);
    #1;
    reset = 1'b1;
    #1;
    check("t5_load_drop", 32'(reg_load), 32'd0);
    check("t5_vtype",     vtype, 32'd0);
    check("t5_vl",        32'(vl), 32'd0);
    check("t5_rsp",       32'(rsp_valid), 32'd0);
    check("t5_ready",     32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_rsp",  32'(rsp_valid), 32'd0);
      check("t5_no_load", 32'(reg_load), 32'd0);
    end

    // T6: ALU first (bus 01), then GACC must switch bus to 00
    send(mkfid(2'd0, 3'd1), mkregs(5'd1, 5'd2, 5'd3), 32'd0);
    check("t6_alu_load", 32'(reg_load), 32'd1);
    check("t6_alu_bus",  32'(bus_sel), 32'd1);
    @(negedge clk);
    check("t6_alu_rsp",     32'(rsp_valid), 32'd1);
    check("t6_alu_payload", rsp_payload_outputs_0, 32'd0);
    @(negedge clk);
    gacc_in = 32'h1234;
    send(mkfid(2'd0, 3'd5), 32'd0, 32'd0);
    gacc_in = 32'hDEAD;
    check("t6_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t6_payload",   rsp_payload_outputs_0, 32'h1234);
    check("t6_bus_sel",   32'(bus_sel), 32'd0);
    check("t6_reg_load",  32'(reg_load), 32'd0);
    @(negedge clk);
    check("t6_idle", 32'(cmd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
